fantasticfft_frame_collector: RTL

Upstream neighbour of the 8-point FFT pipeline. Accepts a serial stream of signed fixed-point real samples over a valid/ready handshake and assembles them into 8-sample frames. Each complete frame is presented in parallel on x0..x7 with a frame-valid strobe that drives the FFT8 isValid input. Frames are double-buffered, so one frame can be collected while the previous one is held.

---
 rtl/fantasticfft_frame_collector.sv | 90 +++++++++
 1 files changed

// File: rtl/fantasticfft_frame_collector.sv
// fantasticfft_frame_collector: assembles a serial sample stream into 8-sample frames for FFT8
//   clk, rst             : clock, asynchronous active-high reset
//   s_data/s_valid/s_sof : input sample stream, s_sof marks the first sample of a frame
//   s_ready              : collector accepts s_data this cycle
//   x0..x7, out_valid    : held frame (x0 = first sample) and its valid strobe
//   out_ready            : downstream takes the held frame
//   drop_cnt             : saturating count of aborted partial frames
//   FANTASTICFFT_PRESCALE_EN : when defined, samples are arithmetic-shifted right by 3 before storage
module fantasticfft_frame_collector #(
    parameter int INT_SIZE = 8,
    parameter int FRAC_SIZE = 8,
    localparam int W = INT_SIZE + FRAC_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    input  logic         s_sof,
    output logic         s_ready,
    output logic [W-1:0] x0,
    output logic [W-1:0] x1,
    output logic [W-1:0] x2,
    output logic [W-1:0] x3,
    output logic [W-1:0] x4,
    output logic [W-1:0] x5,
    output logic [W-1:0] x6,
    output logic [W-1:0] x7,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   drop_cnt
);
    logic [W-1:0] slot [0:6];
    logic [W-1:0] hold [0:7];
    logic [2:0]   wr_idx;
    logic [W-1:0] d;
    logic         accept, complete;

`ifdef FANTASTICFFT_PRESCALE_EN
    assign d = $signed(s_data) >>> 3;
`else
    assign d = s_data;
`endif

    // Stall only when the eighth sample would overwrite a held frame nobody is taking.
    assign s_ready  = !rst && !(wr_idx == 3'd7 && out_valid && !out_ready);
    assign accept   = s_valid && s_ready;
    assign complete = accept && !s_sof && wr_idx == 3'd7;

    // Fill slots need no reset: a frame only completes after all of them are rewritten.
    always_ff @(posedge clk) begin
        if (accept && !complete)
            slot[s_sof ? 3'd0 : wr_idx] <= d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx    <= 3'd0;
            out_valid <= 1'b0;
            drop_cnt  <= 8'd0;
            hold      <= '{default: '0};
        end else begin
            if (accept) begin
                if (s_sof) begin
                    wr_idx <= 3'd1;
                    if (wr_idx != 3'd0 && drop_cnt != 8'hff)
                        drop_cnt <= drop_cnt + 8'd1;
                end else begin
                    wr_idx <= wr_idx + 3'd1;
                end
            end
            if (complete) begin
                for (int i = 0; i < 7; i++)
                    hold[i] <= slot[i];
                hold[7]   <= d;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign x0 = hold[0];
    assign x1 = hold[1];
    assign x2 = hold[2];
    assign x3 = hold[3];
    assign x4 = hold[4];
    assign x5 = hold[5];
    assign x6 = hold[6];
    assign x7 = hold[7];
endmodule
